lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-port write arbiter driving an HX8352 8080-style 16-bit LCD bus.
//
// Port 0 carries configuration/command words and port 1 carries the pixel stream. Each
// accepted word is one bus cycle: SETUP (cs low, wr high), WR_LO for WR_LOW_CYC cycles
// (wr low), then WR_HI for WR_HIGH_CYC cycles (wr high). The last WR_HI cycle doubles as
// the next arbitration point, so back-to-back words keep cs low.
//
// Ports:
//   clk, n_rst          clock; asynchronous active-low reset
//   req0/req1           write request per port, held until ack
//   rs0/rs1             register select for the offered word (0 command, 1 data)
//   data0/data1         offered word
//   ack0/ack1           one-cycle pulse in the grant cycle; the word is latched at that edge
//   busy                FSM is not idle
//   lcd_cs/rs/wr/rd     HX8352 control strobes (cs, wr, rd active-low; rd never asserted)
//   lcd_data            HX8352 data bus
module lcd_bus_arbiter #(
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2,
  parameter int unsigned BURST_MAX   = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rs0,
  input  logic        rs1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_wr,
  output logic        lcd_rd,
  output logic [15:0] lcd_data
);

  typedef enum logic [1:0] {StIdle, StSetup, StWrLo, StWrHi} state_e;

  localparam logic [3:0] LoLast   = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0] HiLast   = 4'(WR_HIGH_CYC - 1);
  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  state_e      state_q, state_d;
  logic [3:0]  cyc_q, cyc_d;
  logic        own_vld_q, own_vld_d;
  logic        own_q, own_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        rr_q, rr_d;          // port granted last
  logic        lcd_rs_q, lcd_rs_d;
  logic [15:0] lcd_data_q, lcd_data_d;

  logic        grant_cycle;
  logic        any_req;
  logic        win;

  assign grant_cycle = (state_q == StIdle) || ((state_q == StWrHi) && (cyc_q == HiLast));
  assign any_req     = req0 | req1;

  // Winner selection; only meaningful when any_req is high.
  always_comb begin
    win = 1'b0;
    if (req0 && !req1) begin
      win = 1'b0;
    end else if (!req0 && req1) begin
      win = 1'b1;
    end else if (own_vld_q) begin
      // Contended: the owner keeps the bus until its burst allowance is used up.
      win = (burst_cnt_q < BurstMax) ? own_q : ~own_q;
    end else begin
      win = ~rr_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    own_vld_d   = own_vld_q;
    own_d       = own_q;
    burst_cnt_d = burst_cnt_q;
    rr_d        = rr_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    ack0        = 1'b0;
    ack1        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cyc_d = 4'd0;
      end
      StSetup: begin
        state_d = StWrLo;
        cyc_d   = 4'd0;
      end
      StWrLo: begin
        if (cyc_q == LoLast) begin
          state_d = StWrHi;
          cyc_d   = 4'd0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StWrHi: begin
        cyc_d = cyc_q + 4'd1;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 4'd0;
      end
    endcase

    if (grant_cycle) begin
      cyc_d = 4'd0;
      if (any_req) begin
        state_d    = StSetup;
        // Gated with reset so no ack escapes while the word cannot be latched.
        ack0       = n_rst & ~win;
        ack1       = n_rst & win;
        rr_d       = win;
        own_vld_d  = 1'b1;
        own_d      = win;
        lcd_rs_d   = win ? rs1 : rs0;
        lcd_data_d = win ? data1 : data0;
        if (own_vld_q && (own_q == win)) begin
          burst_cnt_d = (burst_cnt_q >= BurstMax) ? BurstMax : burst_cnt_q + 8'd1;
        end else begin
          burst_cnt_d = 8'd1;
        end
      end else begin
        state_d     = StIdle;
        own_vld_d   = 1'b0;
        burst_cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      cyc_q       <= 4'd0;
      own_vld_q   <= 1'b0;
      own_q       <= 1'b0;
      burst_cnt_q <= 8'd0;
      rr_q        <= 1'b1;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      own_vld_q   <= own_vld_d;
      own_q       <= own_d;
      burst_cnt_q <= burst_cnt_d;
      rr_q        <= rr_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
    end
  end

  // Strobes decode straight from the state register so reset forces them idle at once.
  assign busy     = (state_q != StIdle);
  assign lcd_cs   = (state_q == StIdle);
  assign lcd_wr   = (state_q != StWrLo);
  assign lcd_rd   = 1'b1;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: a cycle-by-cycle vector table on the default
// configuration plus directed multi-cycle sequences (stream, burst limit, alternation,
// reset in WR_LO, early withdraw). Three instances with different BURST_MAX share inputs.
module tb_lcd_bus_arbiter;

  logic        clk;
  logic        n_rst;
  logic        req0, req1, rs0, rs1;
  logic [15:0] data0, data1;

  logic        ack0_w [3];
  logic        ack1_w [3];
  logic        busy_w [3];
  logic        cs_w   [3];
  logic        rs_w   [3];
  logic        wr_w   [3];
  logic        rd_w   [3];
  logic [15:0] data_w [3];

  logic [1:0]  sel;
  logic        m_ack0, m_ack1, m_busy, m_cs, m_rs, m_wr, m_rd;
  logic [15:0] m_data;

  int n_vec;
  int n_err;

  lcd_bus_arbiter u_dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1), .ack0(ack0_w[0]), .ack1(ack1_w[0]), .busy(busy_w[0]),
    .lcd_cs(cs_w[0]), .lcd_rs(rs_w[0]), .lcd_wr(wr_w[0]), .lcd_rd(rd_w[0]),
    .lcd_data(data_w[0])
  );

  lcd_bus_arbiter #(.BURST_MAX(4)) u_dut_b4 (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1), .ack0(ack0_w[1]), .ack1(ack1_w[1]), .busy(busy_w[1]),
    .lcd_cs(cs_w[1]), .lcd_rs(rs_w[1]), .lcd_wr(wr_w[1]), .lcd_rd(rd_w[1]),
    .lcd_data(data_w[1])
  );

  lcd_bus_arbiter #(.BURST_MAX(1)) u_dut_b1 (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1), .ack0(ack0_w[2]), .ack1(ack1_w[2]), .busy(busy_w[2]),
    .lcd_cs(cs_w[2]), .lcd_rs(rs_w[2]), .lcd_wr(wr_w[2]), .lcd_rd(rd_w[2]),
    .lcd_data(data_w[2])
  );

  assign m_ack0 = ack0_w[sel];
  assign m_ack1 = ack1_w[sel];
  assign m_busy = busy_w[sel];
  assign m_cs   = cs_w[sel];
  assign m_rs   = rs_w[sel];
  assign m_wr   = wr_w[sel];
  assign m_rd   = rd_w[sel];
  assign m_data = data_w[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r0;
    logic        s0;
    logic [15:0] d0;
    logic        r1;
    logic        s1;
    logic [15:0] d1;
    logic [22:0] exp;   // {ack0, ack1, busy, cs, wr, rd, rs, data}
  } vec_t;

  localparam int NTbl = 25;
  vec_t tbl [NTbl];

  logic [15:0] w0 [8];
  logic [15:0] w1 [8];

  int          gport[$];
  int          gcyc[$];
  logic [16:0] gword[$];
  int          fcyc[$];
  logic [16:0] fword[$];
  int          cs_lo_cnt, cs_rise, busy_fall;

  function automatic logic [22:0] o(input logic a0, input logic a1, input logic b,
                                    input logic cs, input logic wr, input logic rs,
                                    input logic [15:0] d);
    return {a0, a1, b, cs, wr, 1'b1, rs, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0; data0 = '0; data1 = '0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  // Reactive two-port requester: each port offers words from its list, updating after ack.
  task automatic run_ports(input int n0, input int start0, input int n1, input int start1,
                           input int ncyc);
    int   i0, i1;
    logic prev_wr, prev_cs, prev_busy;
    i0 = 0; i1 = 0;
    gport.delete(); gcyc.delete(); gword.delete(); fcyc.delete(); fword.delete();
    cs_lo_cnt = 0; cs_rise = 0; busy_fall = -1;
    prev_wr = 1'b1; prev_cs = 1'b1; prev_busy = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      req0  = (c >= start0) && (i0 < n0);
      rs0   = 1'b0;
      data0 = w0[i0[2:0]];
      req1  = (c >= start1) && (i1 < n1);
      rs1   = 1'b1;
      data1 = w1[i1[2:0]];
      @(negedge clk);
      if (m_ack0) begin gport.push_back(0); gcyc.push_back(c); gword.push_back({1'b0, data0}); end
      if (m_ack1) begin gport.push_back(1); gcyc.push_back(c); gword.push_back({1'b1, data1}); end
      if (prev_wr && !m_wr) begin fcyc.push_back(c); fword.push_back({m_rs, m_data}); end
      if (!m_cs) cs_lo_cnt++;
      if (!prev_cs && m_cs) cs_rise++;
      if (prev_busy && !m_busy && busy_fall < 0) busy_fall = c;
      prev_wr = m_wr; prev_cs = m_cs; prev_busy = m_busy;
      if (m_ack0) i0++;
      if (m_ack1) i1++;
      @(posedge clk);
      #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Grant order, 5-cycle spacing, 2-cycle wr latency and latched word for each grant.
  task automatic check_run(input string name, input int n, input logic [7:0] seq);
    check({name, ".grants"}, gport.size(), n);
    for (int k = 0; k < n && k < gport.size(); k++) begin
      check($sformatf("%s.port[%0d]", name, k), gport[k], {31'b0, seq[k]});
      if (k > 0) check($sformatf("%s.period[%0d]", name, k), gcyc[k] - gcyc[k-1], 5);
    end
    check({name, ".wr_falls"}, fcyc.size(), n);
    for (int k = 0; k < fcyc.size() && k < gcyc.size(); k++) begin
      check($sformatf("%s.wr_lat[%0d]", name, k), fcyc[k] - gcyc[k], 2);
      check($sformatf("%s.word[%0d]", name, k), {15'b0, fword[k]}, {15'b0, gword[k]});
    end
  endtask

  initial begin
    int a0_seen, a1_seen, falls;
    logic pw;
    n_vec = 0;
    n_err = 0;
    sel   = 2'd0;

    // ---- Asynchronous reset with both requests high, before any clock edge ----
    req0 = 1'b1; req1 = 1'b1; rs0 = 1'b1; rs1 = 1'b1; data0 = 16'hFFFF; data1 = 16'hFFFF;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1 check("reset_state", {9'b0, m_ack0, m_ack1, m_busy, m_cs, m_wr, m_rd, m_rs, m_data},
             {9'b0, o(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000)});

    // ---- Vector table, default configuration ----
    tbl[0]  = '{1'b1, 1'b0, 16'h0022, 1'b0, 1'b0, 16'h0000, o(1, 0, 0, 1, 1, 0, 16'h0000)};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 0, 16'h0022)};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 0, 16'h0022)};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 0, 16'h0022)};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 0, 16'h0022)};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 0, 16'h0022)};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 0, 1, 1, 0, 16'h0022)};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hABCD, o(0, 1, 0, 1, 1, 0, 16'h0022)};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'hABCD)};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 1, 16'hABCD)};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 1, 16'hABCD)};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'hABCD)};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'hABCD)};
    // Both request from idle; port 1 was granted last, so port 0 wins.
    tbl[13] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b1, 16'h2222, o(1, 0, 0, 1, 1, 1, 16'hABCD)};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, o(0, 0, 1, 0, 1, 0, 16'h1111)};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, o(0, 0, 1, 0, 0, 0, 16'h1111)};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, o(0, 0, 1, 0, 0, 0, 16'h1111)};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, o(0, 0, 1, 0, 1, 0, 16'h1111)};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, o(0, 1, 1, 0, 1, 0, 16'h1111)};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'h2222)};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 1, 16'h2222)};
    tbl[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 0, 1, 16'h2222)};
    tbl[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'h2222)};
    tbl[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 1, 0, 1, 1, 16'h2222)};
    tbl[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, o(0, 0, 0, 1, 1, 1, 16'h2222)};

    do_reset();
    for (int i = 0; i < NTbl; i++) begin
      req0 = tbl[i].r0; rs0 = tbl[i].s0; data0 = tbl[i].d0;
      req1 = tbl[i].r1; rs1 = tbl[i].s1; data1 = tbl[i].d1;
      @(negedge clk);
      check($sformatf("tbl[%0d]", i),
            {9'b0, m_ack0, m_ack1, m_busy, m_cs, m_wr, m_rd, m_rs, m_data}, {9'b0, tbl[i].exp});
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 8; k++) begin
      w0[k] = 16'h0A00 + 16'(k);
      w1[k] = 16'hB000 + 16'(k);
    end

    // ---- Pixel stream on port 1 ----
    w1[0] = 16'hF800; w1[1] = 16'h07E0; w1[2] = 16'h001F; w1[3] = 16'hFFFF;
    sel = 2'd0;
    do_reset();
    run_ports(0, 0, 4, 0, 26);
    check_run("stream", 4, 8'b0000_1111);
    check("stream.cs_low_cycles", cs_lo_cnt, 20);
    check("stream.cs_rises", cs_rise, 1);
    check("stream.idle_cycle", busy_fall, 21);
    for (int k = 0; k < 8; k++) w1[k] = 16'hB000 + 16'(k);

    // ---- Owner keeps the bus under contention while below BURST_MAX ----
    sel = 2'd0;
    do_reset();
    run_ports(3, 0, 2, 0, 30);
    check_run("own_keep", 5, 8'b0001_1000);

    // ---- BURST_MAX=4: port 0 arrives after port 1's first grant ----
    sel = 2'd1;
    do_reset();
    run_ports(1, 1, 5, 0, 35);
    check_run("burst4", 6, 8'b0010_1111);

    // ---- BURST_MAX=1: simultaneous first request, strict alternation ----
    sel = 2'd2;
    do_reset();
    run_ports(2, 0, 2, 0, 25);
    check_run("burst1", 4, 8'b0000_1010);

    // ---- Reset asserted during WR_LO ----
    sel = 2'd0;
    do_reset();
    req0 = 1'b1; rs0 = 1'b0; data0 = 16'h5A5A;
    @(negedge clk);
    check("rst_wrlo.ack0", {31'b0, m_ack0}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_wrlo.wr_low", {31'b0, m_wr}, 32'd0);
    #2 n_rst = 1'b0;
    #1 check("rst_wrlo.async", {27'b0, m_wr, m_cs, m_busy, m_ack0, m_rd}, 32'b11001);
    @(posedge clk);
    #1 n_rst = 1'b1;
    w0[0] = 16'h5A5A;
    run_ports(1, 0, 0, 0, 10);
    check_run("rst_wrlo", 1, 8'b0000_0000);
    check("rst_wrlo.cs_low_cycles", cs_lo_cnt, 5);
    check("rst_wrlo.idle_cycle", busy_fall, 6);

    // ---- Early withdraw: one-cycle req1 pulse while port 0 is in WR_LO ----
    sel = 2'd0;
    do_reset();
    a0_seen = 0; a1_seen = 0; falls = 0; pw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req0 = (c == 0); rs0 = 1'b0; data0 = 16'h1234;
      req1 = (c == 2); rs1 = 1'b1; data1 = 16'h4321;
      @(negedge clk);
      if (m_ack0) a0_seen++;
      if (m_ack1) a1_seen++;
      if (pw && !m_wr) falls++;
      pw = m_wr;
      if (c == 6) check("withdraw.idle", {30'b0, m_busy, m_cs}, 32'b01);
      @(posedge clk);
      #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("withdraw.ack0", a0_seen, 1);
    check("withdraw.ack1", a1_seen, 0);
    check("withdraw.wr_falls", falls, 1);
    check("withdraw.data", {16'b0, m_data}, 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
